// File: rtl/execution_skid_registers_pkg.sv
// Shared defaults and state encoding for the EX/MEM skid registers and the
// skid_buffer that later pipeline stages also reuse.
package execution_skid_registers_pkg;

    localparam int DEF_WORD_WIDTH           = 32;
    localparam int DEF_REGISTER_INDEX_WIDTH = 5;
    localparam int DEF_STALL_CNT_WIDTH      = 16;

    // The encoding equals the number of held entries, so occupancy is the state itself.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    function automatic logic [1:0] state_occupancy(input skid_state_e s);
        return s;
    endfunction

endpackage

// File: rtl/execution_skid_registers_skid_buffer.sv
// Two-entry (head + skid) valid/ready buffer over a packed payload. Masks let the
// owner zero selected head bits on flush or when the head drains to empty.
module skid_buffer
    import execution_skid_registers_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 8,
    parameter logic [DATA_WIDTH-1:0] FLUSH_CLR_MASK = '0,
    parameter logic [DATA_WIDTH-1:0] DRAIN_CLR_MASK = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            occupancy
);

    skid_state_e           state;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] skid;
    logic                  push;
    logic                  pop;

    // Ready depends only on state, so no combinational path through out_ready.
    assign in_ready  = (state != ST_TWO);
    assign out_valid = (state != ST_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = head;
    assign occupancy = state_occupancy(state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
            head  <= '0;
            skid  <= '0;
        end else if (flush) begin
            state <= ST_EMPTY;
            head  <= head & ~FLUSH_CLR_MASK;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (push) begin
                        head  <= in_data;
                        state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        head <= in_data;
                    end else if (push) begin
                        skid  <= in_data;
                        state <= ST_TWO;
                    end else if (pop) begin
                        head  <= head & ~DRAIN_CLR_MASK;
                        state <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        head  <= skid;
                        state <= ST_ONE;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/execution_skid_registers.sv
// EX->MEM pipeline skid registers. Define EXEC_SKID_STALL_COUNT_EN to build the
// saturating backpressure counter on stall_cycles; otherwise it reads 0.
module execution_skid_registers
    import execution_skid_registers_pkg::*;
#(
    parameter int WORD_WIDTH           = DEF_WORD_WIDTH,
    parameter int REGISTER_INDEX_WIDTH = DEF_REGISTER_INDEX_WIDTH,
    parameter int STALL_CNT_WIDTH      = DEF_STALL_CNT_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WORD_WIDTH-1:0]           extended_inmediate_in,
    input  logic                            cu_mem_to_reg_in,
    input  logic                            cu_reg_write_in,
    input  logic [REGISTER_INDEX_WIDTH-1:0] destination_register_in,
    input  logic [WORD_WIDTH-1:0]           alu_result_in,
    input  logic                            alu_zero_in,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WORD_WIDTH-1:0]           extended_inmediate_out,
    output logic                            cu_mem_to_reg_out,
    output logic                            cu_reg_write_out,
    output logic [REGISTER_INDEX_WIDTH-1:0] destination_register_out,
    output logic [WORD_WIDTH-1:0]           alu_result_out,
    output logic                            alu_zero_out,
    output logic [1:0]                      occupancy,
    output logic [STALL_CNT_WIDTH-1:0]      stall_cycles
);

    // Payload layout: {imm, mem_to_reg, reg_write, dest, alu_result, zero}
    localparam int DW            = 2 * WORD_WIDTH + REGISTER_INDEX_WIDTH + 3;
    localparam int REG_WRITE_BIT = WORD_WIDTH + REGISTER_INDEX_WIDTH + 1;
    localparam int MEM_TO_REG_BIT = WORD_WIDTH + REGISTER_INDEX_WIDTH + 2;
    localparam logic [DW-1:0] REG_WRITE_MASK  = DW'(1) << REG_WRITE_BIT;
    localparam logic [DW-1:0] MEM_TO_REG_MASK = DW'(1) << MEM_TO_REG_BIT;

    logic [DW-1:0] in_data;
    logic [DW-1:0] head_data;

    assign in_data = {extended_inmediate_in, cu_mem_to_reg_in, cu_reg_write_in,
                      destination_register_in, alu_result_in, alu_zero_in};

    assign {extended_inmediate_out, cu_mem_to_reg_out, cu_reg_write_out,
            destination_register_out, alu_result_out, alu_zero_out} = head_data;

    // A flushed head must not write back or load; a drained head must not write back.
    skid_buffer #(
        .DATA_WIDTH    (DW),
        .FLUSH_CLR_MASK(REG_WRITE_MASK | MEM_TO_REG_MASK),
        .DRAIN_CLR_MASK(REG_WRITE_MASK)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (head_data),
        .occupancy(occupancy)
    );

`ifdef EXEC_SKID_STALL_COUNT_EN
    logic [STALL_CNT_WIDTH-1:0] stall_q;

    // Flush deliberately leaves the count alone; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_q <= stall_q + STALL_CNT_WIDTH'(1);
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: doc/execution_skid_registers.md
EXECUTION_SKID_REGISTERS -- requirements
Module: execution_skid_registers

Interface
REQ-001 Parameter WORD_WIDTH, default 32, width of ALU result and extended immediate.
REQ-002 Parameter REGISTER_INDEX_WIDTH, default 5, width of destination register index.
REQ-003 Parameter STALL_CNT_WIDTH, default 16, width of stall counter.
REQ-004 Clocking SHALL be: one clock; reset is asynchronous and active-low.
REQ-005 Port list SHALL be:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  discard all held and incoming entries.
- in_valid  in  1  EX stage offers entry.
- in_ready  out  1  block can accept entry.
- extended_inmediate_in  in  WORD_WIDTH  sign-extended immediate.
- cu_mem_to_reg_in  in  1  control: writeback from memory.
- cu_reg_write_in  in  1  control: register write enable.
- destination_register_in  in  REGISTER_INDEX_WIDTH  destination index.
- alu_result_in  in  WORD_WIDTH  ALU result.
- alu_zero_in  in  1  ALU zero flag.
- out_valid  out  1  head entry valid to MEM stage.
- out_ready  in  1  MEM stage consumes head.
- extended_inmediate_out, cu_mem_to_reg_out, cu_reg_write_out, destination_register_out, alu_result_out, alu_zero_out  out  matching widths  head entry fields.
- occupancy  out  2  entries held (0..2).
- stall_cycles  out  STALL_CNT_WIDTH  backpressure cycle count (macro-dependent).

Function
REQ-006 Block SHALL be a 2-entry buffer (head + skid), states EMPTY, ONE, TWO; occupancy SHALL equal 0/1/2 respectively.
REQ-007 Push = in_valid && in_ready; pop = out_valid && out_ready; both sampled at rising clk.
REQ-008 in_ready SHALL be high iff state != TWO (combinational from state only, never from out_ready).
REQ-009 out_valid SHALL be high iff state != EMPTY.
REQ-010 Latency: entry pushed at edge N SHALL appear on outputs with out_valid high after edge N when buffer was EMPTY, or after head is popped otherwise.
REQ-011 Transitions: EMPTY+push->ONE; ONE+push only->TWO; ONE+pop only->EMPTY; ONE+push+pop->ONE (head loads input); TWO+pop->ONE (head loads skid); TWO ignores in_valid.
REQ-012 Order SHALL be strict FIFO; no entry SHALL be dropped or duplicated absent flush.
REQ-013 Output fields SHALL be driven directly from the head register (no combinational path from inputs to outputs).
REQ-014 Flush SHALL have priority over push/pop: next state EMPTY, in-cycle input discarded, cu_reg_write_out and cu_mem_to_reg_out cleared to 0; data fields hold.
REQ-015 When EMPTY, head fields SHALL hold last value; cu_reg_write_out SHALL be 0 after the head is popped to EMPTY.

Reset
REQ-016 rst_n low SHALL immediately force state EMPTY, all data/control outputs 0, occupancy 0, stall_cycles 0, out_valid 0.
REQ-017 Reset asserted mid-transfer SHALL discard both entries; first push after release SHALL behave as from EMPTY.

Configuration
REQ-018 Macro EXEC_SKID_STALL_COUNT_EN defined: stall_cycles SHALL increment each cycle with out_valid && !out_ready, saturating at all-ones, cleared only by reset (not flush).
REQ-019 Macro undefined: stall_cycles SHALL be tied to 0 and no counter register SHALL be synthesised.

Structure
REQ-020 WORD_WIDTH, REGISTER_INDEX_WIDTH defaults and state encoding localparams SHALL live in shared src/parameters.v.
REQ-021 Payload storage SHALL use one sub-module skid_buffer, parametrised by packed DATA_WIDTH, reused by later pipeline stages.

Verification
REQ-022 Reset then push alu_result 0x0000_00AA, out_ready=1 -> out_valid next cycle, alu_result_out=0xAA, occupancy 1.
REQ-023 out_ready=0, push 0x11 then 0x22 -> occupancy 2, in_ready 0; third push 0x33 ignored; release out_ready -> 0x11, 0x22 in order.
REQ-024 Continuous push 1..8 with out_ready=1 -> one output per cycle, values 1..8, occupancy constant 1.
REQ-025 Occupancy 2, cu_reg_write=1, flush with simultaneous push 0x44 -> next cycle out_valid 0, cu_reg_write_out 0, 0x44 never appears.
REQ-026 Macro on, STALL_CNT_WIDTH=4, out_valid held 20 cycles with out_ready=0 -> stall_cycles=0xF; macro off -> 0.
REQ-027 rst_n pulled low mid-cycle at occupancy 2 -> outputs 0 asynchronously; after release push 0x55 -> appears alone.
